// File: rtl/bcd_pkg.sv
// bcd_pkg: shared constants, FSM state type and width helper for the BCD decoder
package bcd_pkg;
  localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;
  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;
  // smallest w with 2^w > 10^digits - 1
  function automatic int bcd_bin_width(input int digits);
    longint m;
    int w;
    m = 1;
    for (int i = 0; i < digits; i++) m = m * 10;
    m = m - 1;
    w = 1;
    while ((longint'(1) << w) <= m) w++;
    return w;
  endfunction
endpackage

// File: rtl/bcd_digit_mac.sv
// bcd_digit_mac: combinational acc*10+d step with non-decimal digit flag
// ports: acc (running value), d (BCD digit), acc_next (acc*10+d truncated), digit_bad (d>9)
module bcd_digit_mac
  import bcd_pkg::*;
#(
  parameter int BIN_W = 14
) (
  input  logic [BIN_W-1:0] acc,
  input  logic [3:0]       d,
  output logic [BIN_W-1:0] acc_next,
  output logic             digit_bad
);
  assign acc_next  = (acc << 3) + (acc << 1) + BIN_W'(d);
  assign digit_bad = d > BCD_MAX_DIGIT;
endmodule

// File: rtl/bcd_to_bin_decoder.sv
// bcd_to_bin_decoder: digit-serial packed BCD to binary converter, MSD first
// ports: clk, rst (sync active-high); in_valid/in_ready/in_bcd (word in);
//        out_valid/out_ready/out_bin/out_err (result out, out_bin=0 on error)
// BCD_EARLY_ABORT_EN: when defined, the first non-decimal digit ends conversion at once
module bcd_to_bin_decoder
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   in_bcd,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [BIN_W-1:0]      out_bin,
  output logic                  out_err
);
  localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  if (BIN_W < bcd_bin_width(DIGITS)) begin : g_width_check
    $error("BIN_W too small for DIGITS");
  end
  state_t                state, state_n;
  logic [BIN_W-1:0]      acc, acc_n, mac;
  logic [4*DIGITS-1:0]   sr, sr_n;
  logic [CW-1:0]         cnt, cnt_n;
  logic                  err, err_n, bad;
  bcd_digit_mac #(.BIN_W(BIN_W)) u_mac (
    .acc       (acc),
    .d         (sr[4*DIGITS-1 -: 4]),
    .acc_next  (mac),
    .digit_bad (bad)
  );
  // gated by rst so nothing is offered while reset is held
  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = state == DONE;
  assign out_err   = out_valid && err;
  assign out_bin   = (out_valid && !err) ? acc : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      acc   <= '0;
      sr    <= '0;
      cnt   <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_n;
      acc   <= acc_n;
      sr    <= sr_n;
      cnt   <= cnt_n;
      err   <= err_n;
    end
  end
  always_comb begin
    state_n = state;
    acc_n   = acc;
    sr_n    = sr;
    cnt_n   = cnt;
    err_n   = err;
    case (state)
      IDLE: if (in_valid) begin
        sr_n    = in_bcd;
        acc_n   = '0;
        err_n   = 1'b0;
        cnt_n   = CW'(DIGITS - 1);
        state_n = CONV;
      end
      CONV: begin
        acc_n   = mac;
        err_n   = err | bad;
        sr_n    = sr << 4;
        cnt_n   = cnt - CW'(1);
        state_n = (cnt == '0) ? DONE : CONV;
`ifdef BCD_EARLY_ABORT_EN
        if (bad) state_n = DONE;
`else
`endif
      end
      DONE: if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_bcd_to_bin_decoder.sv
// tb_bcd_to_bin_decoder: scoreboard bench for bcd_to_bin_decoder with directed vectors
module tb_bcd_to_bin_decoder;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_bcd;
  logic        out_valid;
  logic        out_ready;
  logic [13:0] out_bin;
  logic        out_err;
  typedef struct {
    logic [13:0] bin;
    logic        err;
    int          lat;
  } exp_t;
  exp_t exp_q[$];
  int   acc_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   lat;
  logic prev_v = 1'b0;
  logic chk_ready = 1'b0;
  logic [13:0] hold_bin;
  logic        hold_err;
  bcd_to_bin_decoder #(.DIGITS(4), .BIN_W(14)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_bcd    (in_bcd),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bin   (out_bin),
    .out_err   (out_err)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (rst) begin
      acc_q.delete();
      prev_v    = 1'b0;
      chk_ready = 1'b0;
    end else begin
      if (chk_ready) begin
        chk("in_ready_after_handshake", {31'd0, in_ready}, 32'd1);
        chk_ready = 1'b0;
      end
      if (in_valid && in_ready) acc_q.push_back(cyc + 1);
      if (out_valid && !prev_v) begin
        lat      = (acc_q.size() > 0) ? cyc - acc_q.pop_front() : -1;
        hold_bin = out_bin;
        hold_err = out_err;
      end else if (out_valid) begin
        chk("hold_bin", {18'd0, out_bin}, {18'd0, hold_bin});
        chk("hold_err", {31'd0, out_err}, {31'd0, hold_err});
        chk("in_ready_busy", {31'd0, in_ready}, 32'd0);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got bin %0d err %0d expected no output", out_bin, out_err);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("out_bin", {18'd0, out_bin}, {18'd0, e.bin});
          chk("out_err", {31'd0, out_err}, {31'd0, e.err});
          chk("latency", lat, e.lat);
        end
        chk_ready = 1'b1;
      end
      prev_v = out_valid;
    end
  end
  task automatic send_raw(input logic [15:0] w);
    int n;
    @(posedge clk);
    #1 in_valid = 1'b1;
    in_bcd = w;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 50);
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got in_ready 0 expected 1");
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask
  task automatic send(input logic [15:0] w, input logic [13:0] b, input logic e, input int l);
    exp_t x;
    x.bin = b;
    x.err = e;
    x.lat = l;
    exp_q.push_back(x);
    send_raw(w);
  endtask
  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask
  initial begin
    int n;
    rst       = 1'b1;
    in_valid  = 1'b1;
    in_bcd    = 16'h1234;
    out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_out_bin", {18'd0, out_bin}, 32'd0);
      chk("rst_out_err", {31'd0, out_err}, 32'd0);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    repeat (3) begin
      @(negedge clk);
      chk("no_capture", {31'd0, out_valid}, 32'd0);
    end
    send(16'h1234, 14'd1234, 1'b0, 4);
    drain();
    send(16'h0000, 14'd0, 1'b0, 4);
    send(16'h9999, 14'd9999, 1'b0, 4);
    send(16'h0001, 14'd1, 1'b0, 4);
    send(16'h0010, 14'd10, 1'b0, 4);
    drain();
`ifdef BCD_EARLY_ABORT_EN
    send(16'h12A4, 14'd0, 1'b1, 3);
    send(16'hF000, 14'd0, 1'b1, 1);
`else
    send(16'h12A4, 14'd0, 1'b1, 4);
    send(16'hF000, 14'd0, 1'b1, 4);
`endif
    drain();
    out_ready = 1'b0;
    send(16'h0507, 14'd507, 1'b0, 4);
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
    repeat (5) @(posedge clk);
    #1 out_ready = 1'b1;
    drain();
    send_raw(16'h4321);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (8) begin
      @(negedge clk);
      chk("aborted_no_output", {31'd0, out_valid}, 32'd0);
    end
    send(16'h0042, 14'd42, 1'b0, 4);
    drain();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
